// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store port with byte lanes, load extension, timeout and error codes.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise addresses are force-aligned to the access size.
module lsu_mem_port #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int SW    = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
  state_t              state_q;
  logic                wen_q, uns_q;
  logic [1:0]          size_q, err_q;
  logic [OFF_W-1:0]    off_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NB-1:0]       strb_q;
  logic [XLEN-1:0]     wdata_q, rdata_q;
  logic [15:0]         cnt_q;
  logic [OFF_W-1:0]    amask, off_d;
  logic                mis, ill;
  logic [3:0]          nbytes;
  logic [15:0]         strb_full;
  logic [XLEN-1:0]     sh, tmp, zx, ext;
  logic signed [XLEN-1:0] sx;
  logic [SW-1:0]       lsh;
  assign req_ready  = state_q == IDLE;
  assign mem_req    = state_q == MEM;
  assign resp_valid = state_q == RESP;
  assign mem_we     = mem_req & wen_q;
  assign mem_addr   = addr_q;
  assign mem_wstrb  = strb_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  always_comb begin
    amask     = OFF_W'((4'd1 << req_size) - 4'd1);
    ill       = (XLEN == 32) && (req_size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    mis       = |(req_addr[OFF_W-1:0] & amask);
    off_d     = req_addr[OFF_W-1:0];
`else
    mis       = 1'b0;
    off_d     = req_addr[OFF_W-1:0] & ~amask;
`endif
    nbytes    = 4'd1 << req_size;
    strb_full = ((16'd1 << nbytes) - 16'd1) << off_d;
    // Move the addressed lane to bit 0, then sign/zero-extend via a left/right shift pair.
    sh        = mem_rdata >> {off_q, 3'b000};
    lsh       = SW'(XLEN - (8 << size_q));
    tmp       = sh << lsh;
    zx        = tmp >> lsh;
    sx        = $signed(tmp) >>> lsh;
    ext       = uns_q ? zx : sx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      err_q   <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          wen_q   <= req_wen;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          off_q   <= off_d;
          addr_q  <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          strb_q  <= req_wen ? strb_full[NB-1:0] : '0;
          wdata_q <= req_wdata << {off_d, 3'b000};
          rdata_q <= '0;
          cnt_q   <= '0;
          err_q   <= ill ? 2'd3 : mis ? 2'd1 : 2'd0;
          state_q <= (ill | mis) ? RESP : MEM;
        end
        MEM: if (mem_ack) begin
          rdata_q <= wen_q ? '0 : ext;
          err_q   <= 2'd0;
          state_q <= RESP;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          rdata_q <= '0;
          err_q   <= 2'd2;
          state_q <= RESP;
        end else begin
          cnt_q   <= cnt_q + 16'd1;
        end
        RESP: if (resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed checks of lsu_mem_port (XLEN 64, TIMEOUT 4).
module tb_lsu_mem_port;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, req_wen = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0, resp_err;
  logic [63:0] req_addr = 0, req_wdata = 0, resp_rdata, mem_addr, mem_wdata, mem_rdata = 0;
  logic        resp_valid, resp_ready = 0, mem_req, mem_we, mem_ack = 0;
  logic [7:0]  mem_wstrb;
  int checks = 0, errors = 0;

  lsu_mem_port #(.XLEN(64), .ADDR_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic w, input logic [1:0] sz, input logic un, input logic [63:0] a, input logic [63:0] wd);
    req_valid = 1; req_wen = w; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    step();
    req_valid = 0;
  endtask

  task automatic run_load(input logic [1:0] sz, input logic un, input logic [63:0] a, input logic [63:0] rd,
                          output logic rq, output logic v, output logic [63:0] got, output logic [1:0] e);
    start(0, sz, un, a, 64'd0);
    rq = mem_req; mem_rdata = rd; mem_ack = 1;
    step();
    mem_ack = 0; v = resp_valid; got = resp_rdata; e = resp_err; resp_ready = 1;
    step();
    resp_ready = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %0h exp 1", req_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0h exp 0", mem_req); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %0h exp 0", resp_valid); end
    checks++; if ({resp_err, resp_rdata, mem_wstrb, mem_we} !== '0) begin errors++; $display("FAIL rst_outputs got %h exp 0", {resp_err, resp_rdata, mem_wstrb, mem_we}); end
    step(); rst_n = 1; step();
  endtask

  task automatic test_store_byte();
    start(1, 2'd0, 0, 64'h8000_0005, 64'hAB);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sb_mem_req got %0h exp 1", mem_req); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sb_mem_we got %0h exp 1", mem_we); end
    checks++; if (mem_addr !== 64'h8000_0000) begin errors++; $display("FAIL sb_addr got %h exp 80000000", mem_addr); end
    checks++; if (mem_wstrb !== 8'h20) begin errors++; $display("FAIL sb_wstrb got %h exp 20", mem_wstrb); end
    checks++; if (mem_wdata !== 64'h0000_AB00_0000_0000) begin errors++; $display("FAIL sb_wdata got %h exp 0000ab0000000000", mem_wdata); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sb_early_resp got %0h exp 0", resp_valid); end
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; mem_ack = 1;
    step();
    mem_ack = 0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sb_resp_valid got %0h exp 1", resp_valid); end
    checks++; if (resp_err !== 2'd0) begin errors++; $display("FAIL sb_err got %0d exp 0", resp_err); end
    checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL sb_rdata got %h exp 0", resp_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sb_req_drop got %0h exp 0", mem_req); end
    resp_ready = 1; step(); resp_ready = 0;
    checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL sb_back_idle got %b exp 10", {req_ready, resp_valid}); end
  endtask

  task automatic test_store_lanes();
    start(1, 2'd1, 0, 64'h8000_0002, 64'h1234);
    checks++; if ({mem_wstrb, mem_wdata} !== {8'h0C, 64'h0000_0000_1234_0000}) begin errors++; $display("FAIL sh_lane got %h/%h exp 0c/0000000012340000", mem_wstrb, mem_wdata); end
    mem_ack = 1; step(); mem_ack = 0; resp_ready = 1; step(); resp_ready = 0;
    start(1, 2'd2, 0, 64'h8000_0004, 64'hDEAD_BEEF);
    checks++; if ({mem_wstrb, mem_wdata} !== {8'hF0, 64'hDEAD_BEEF_0000_0000}) begin errors++; $display("FAIL sw_lane got %h/%h exp f0/deadbeef00000000", mem_wstrb, mem_wdata); end
    mem_ack = 1; step(); mem_ack = 0; resp_ready = 1; step(); resp_ready = 0;
  endtask

  task automatic test_load_ext();
    logic rq, v; logic [63:0] got; logic [1:0] e;
    run_load(2'd1, 0, 64'h8000_0006, 64'h8001_0000_0000_0000, rq, v, got, e);
    checks++; if ({rq, v, e} !== 4'b1100) begin errors++; $display("FAIL lh_handshake got %b exp 1100", {rq, v, e}); end
    checks++; if (got !== 64'hFFFF_FFFF_FFFF_8001) begin errors++; $display("FAIL lh_signed got %h exp ffffffffffff8001", got); end
    run_load(2'd1, 1, 64'h8000_0006, 64'h8001_0000_0000_0000, rq, v, got, e);
    checks++; if (got !== 64'h0000_0000_0000_8001) begin errors++; $display("FAIL lh_unsigned got %h exp 0000000000008001", got); end
    run_load(2'd0, 0, 64'h8000_0001, 64'h0000_0000_0000_7F00, rq, v, got, e);
    checks++; if (got !== 64'h0000_0000_0000_007F) begin errors++; $display("FAIL lb_pos got %h exp 7f", got); end
    run_load(2'd3, 0, 64'h8000_0008, 64'h8877_6655_4433_2211, rq, v, got, e);
    checks++; if (got !== 64'h8877_6655_4433_2211) begin errors++; $display("FAIL ld_pass got %h exp 8877665544332211", got); end
  endtask

  task automatic test_misalign();
    start(0, 2'd2, 0, 64'h8000_0002, 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if ({mem_req, resp_valid, resp_err} !== 4'b0101) begin errors++; $display("FAIL mis_trap got %b exp 0101", {mem_req, resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL mis_rdata got %h exp 0", resp_rdata); end
    resp_ready = 1; step(); resp_ready = 0;
`else
    checks++; if ({mem_req, mem_addr} !== {1'b1, 64'h8000_0000}) begin errors++; $display("FAIL mis_align got %0h/%h exp 1/80000000", mem_req, mem_addr); end
    mem_rdata = 64'h0000_0000_FFFF_FFFE; mem_ack = 1; step(); mem_ack = 0;
    checks++; if ({resp_valid, resp_err} !== 3'b100) begin errors++; $display("FAIL mis_resp got %b exp 100", {resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mis_rdata got %h exp fffffffffffffffe", resp_rdata); end
    resp_ready = 1; step(); resp_ready = 0;
`endif
  endtask

  task automatic test_timeout();
    int n = 0;
    mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    start(0, 2'd3, 0, 64'h8000_0008, 64'd0);
    for (int i = 0; i < 20 && mem_req; i++) begin n++; step(); end
    checks++; if (n !== 4) begin errors++; $display("FAIL to_req_cycles got %0d exp 4", n); end
    checks++; if ({resp_valid, resp_err} !== 3'b110) begin errors++; $display("FAIL to_err got %b exp 110", {resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL to_rdata got %h exp 0", resp_rdata); end
    resp_ready = 1; step(); resp_ready = 0;
    start(0, 2'd0, 1, 64'h8000_0003, 64'd0);
    mem_rdata = 64'h0000_0000_AB00_0000;
    step(); step(); step();
    mem_ack = 1; step(); mem_ack = 0;
    checks++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 2'd0, 64'hAB}) begin errors++; $display("FAIL to_ack_prio got %0h/%0d/%h exp 1/0/ab", resp_valid, resp_err, resp_rdata); end
    resp_ready = 1; step(); resp_ready = 0;
  endtask

  task automatic test_backpressure();
    start(0, 2'd2, 1, 64'h8000_0010, 64'd0);
    mem_rdata = 64'h1111_2222_9876_5432; mem_ack = 1; step(); mem_ack = 0; mem_rdata = 64'd0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b1, 1'b0, 2'd0, 64'h9876_5432}) begin errors++; $display("FAIL bp_hold%0d got %0h/%0h/%0d/%h exp 1/0/0/98765432", i, resp_valid, req_ready, resp_err, resp_rdata); end
      step();
    end
    resp_ready = 1; step(); resp_ready = 0;
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b exp 01", {resp_valid, req_ready}); end
  endtask

  task automatic test_reset_mid();
    start(0, 2'd3, 0, 64'h8000_0020, 64'd0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_in_mem got %0h exp 1", mem_req); end
    #1 rst_n = 0; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_async_drop got %0h exp 0", mem_req); end
    step(); rst_n = 1; mem_ack = 1; step(); mem_ack = 0;
    checks++; if ({req_ready, resp_valid, mem_req} !== 3'b100) begin errors++; $display("FAIL rm_after got %b exp 100", {req_ready, resp_valid, mem_req}); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_resp got %0h exp 0", resp_valid); end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_lanes();
    test_load_ext();
    test_misalign();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Parametrised load/store port between the NPC core datapath and the data-memory backend (the DPI-backed memory model or a bus bridge).
- Accepts one load or store request at a time over a valid/ready handshake and converts address and size into an aligned bus address, byte strobes and lane-shifted write data.
- Waits for a memory acknowledge, then returns a zero- or sign-extended load result with an error code.
- Next generation of the single-cycle memory access path: adds a configurable data width, a handshake, a timeout and error reporting.

Parameters:
- XLEN, 64, data width in bits; legal values 32 or 64. NB = XLEN/8, OFF_W = log2(NB).
- ADDR_W, 64, address width in bits.
- TIMEOUT, 255, number of cycles waited for mem_ack before a bus error is reported; legal range 1..65535.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load result is zero-extended when 1, sign-extended when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and on error.
- resp_err  out  2  0 = ok, 1 = misaligned, 2 = bus timeout, 3 = illegal size.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  req_addr with the low OFF_W bits cleared.
- mem_wstrb  out  NB  byte strobes; all zero on loads.
- mem_wdata  out  XLEN  store data shifted into its byte lane.
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  XLEN  full aligned memory word.

Behaviour:
- Reset (asynchronous, immediate): FSM goes to IDLE. All outputs are 0 except req_ready = 1. Timeout counter is cleared. Reset in any state aborts the access: mem_req drops combinationally with rst_n, and no response is produced.
- FSM state IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch all req_* fields and compute the error.
  - Illegal size (req_size = 3 with XLEN = 32) gives err 3; a misaligned access gives err 1 (see Optional Feature). Either error goes straight to RESP; mem_req is never asserted.
  - Otherwise go to MEM.
- FSM state MEM:
  - mem_req = 1; mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until the acknowledge.
  - off = addr[OFF_W-1:0]; nbytes = 1 << size.
  - mem_wstrb = ((1 << nbytes) - 1) << off, truncated to NB bits.
  - mem_wdata = wdata << (8*off).
  - On mem_ack, capture data = (mem_rdata >> 8*off) masked to 8*nbytes bits. Sign-extend from bit 8*nbytes-1 unless unsigned; a double is passed through unchanged. Go to RESP with err 0.
  - The counter increments each cycle without ack. When it reaches TIMEOUT, go to RESP with err 2 and resp_rdata = 0; mem_req deasserts the next cycle.
  - An ack in the same cycle as the timeout takes priority (err 0).
- FSM state RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable while resp_ready = 0.
  - On resp_ready, go to IDLE. req_ready rises in the following cycle; there is no same-cycle back-to-back accept.
- Latency: the request is accepted in cycle 0, mem_req is high in cycle 1; an ack in cycle 1 gives resp_valid in cycle 2. Error requests give resp_valid in cycle 1.
- Stores return resp_rdata = 0.
- At most one outstanding access at any time.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: an access whose address is not a multiple of (1 << size) returns err 1 with no memory access.
- Undefined: the address is force-aligned (low size bits cleared) before the lane computation, and err 1 is never produced.

Test Plan:
- Store byte (XLEN = 64), addr 0x80000005, wdata 0xAB -> mem_addr 0x80000000, mem_wstrb 0x20, mem_wdata 0x0000AB0000000000, mem_we 1; ack immediately -> resp_valid in cycle 2, err 0, rdata 0.
- Load half signed, addr 0x80000006, mem_rdata 0x8001000000000000 -> resp_rdata 0xFFFFFFFFFFFF8001. The same access with req_unsigned = 1 -> resp_rdata 0x0000000000008001.
- Load word at addr 0x80000002:
  - Macro defined -> no mem_req, resp_valid in cycle 1, err 1.
  - Macro undefined -> mem_addr 0x80000000; with mem_rdata 0x00000000FFFFFFFE and signed load -> resp_rdata 0xFFFFFFFFFFFFFFFE.
- Load with mem_ack held low and TIMEOUT = 4 -> mem_req high for exactly 4 cycles, then resp_err 2 and resp_rdata 0.
- Load with resp_ready held low 3 cycles -> resp_valid, resp_rdata and resp_err stable; req_ready stays 0.
- rst_n pulsed low during MEM -> mem_req 0 immediately; after release req_ready = 1 and no response is produced.
